// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and constants for the GCD request scheduler.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // Requester index width; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_FLAG  = 1'b0;

endpackage

// File: rtl/gcd_rr_arb.sv
// gcd_rr_arb: combinational rotating-priority picker.
// Searches req_valid from ptr upward with wrap and returns the first hit.
module gcd_rr_arb
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    grant_idx,
  output logic [NUM_REQ-1:0] grant_oh
);

  // ptr < NUM_REQ and offset < NUM_REQ, so one conditional subtract wraps the sum.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    any       = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!any && req_valid[idx]) begin
        any           = 1'b1;
        grant_idx     = idx;
        grant_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_sched.sv
// gcd_sched: shares one GCD engine among NUM_REQ requesters, round-robin.
// Optional watchdog in WAIT enabled by defining GCD_SCHED_TIMEOUT_EN.
module gcd_sched
  import gcd_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int WIDTH          = 32,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int ID_W           = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     eng_start,
  output logic [WIDTH-1:0]         eng_a,
  output logic [WIDTH-1:0]         eng_b,
  output logic                     eng_abort,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_err,
  output logic                     busy
);

  state_t            state, state_n;
  logic [ID_W-1:0]   ptr, ptr_n;
  logic [ID_W-1:0]   id_q, id_n;
  logic [WIDTH-1:0]  a_q, a_n, b_q, b_n;
  logic [WIDTH-1:0]  res_q, res_n;
  logic              err_q, err_n;

  logic              any;
  logic [ID_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_oh;
  logic [WIDTH-1:0]  a_arr [NUM_REQ];
  logic [WIDTH-1:0]  b_arr [NUM_REQ];
  logic [WIDTH-1:0]  sel_a, sel_b;

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]     timer, timer_n;
`endif

  gcd_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr),
    .any       (any),
    .grant_idx (grant_idx),
    .grant_oh  (grant_oh)
  );

  // Split the flat operand buses into per-requester slices.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  assign sel_a = a_arr[grant_idx];
  assign sel_b = b_arr[grant_idx];

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_STATE;
      ptr   <= '0;
      id_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      err_q <= RST_FLAG;
`ifdef GCD_SCHED_TIMEOUT_EN
      timer <= '0;
`endif
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      id_q  <= id_n;
      a_q   <= a_n;
      b_q   <= b_n;
      res_q <= res_n;
      err_q <= err_n;
`ifdef GCD_SCHED_TIMEOUT_EN
      timer <= timer_n;
`endif
    end
  end

  // Next-state, register updates and handshake strobes.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    id_n      = id_q;
    a_n       = a_q;
    b_n       = b_q;
    res_n     = res_q;
    err_n     = err_q;
    req_ready = '0;
    eng_start = 1'b0;
    eng_abort = 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
    timer_n   = timer;
`endif
    case (state)
      IDLE: begin
        if (any) begin
          req_ready = grant_oh;
          a_n       = sel_a;
          b_n       = sel_b;
          id_n      = grant_idx;
          err_n     = 1'b0;
          if (sel_a == '0 || sel_b == '0) begin
            // gcd(0,x) = x and gcd(0,0) = 0, so the OR is the answer.
            res_n   = sel_a | sel_b;
            state_n = RESP;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_n   = WAIT;
`ifdef GCD_SCHED_TIMEOUT_EN
        timer_n   = '0;
`endif
      end
      WAIT: begin
        if (eng_done) begin
          res_n   = eng_result;
          err_n   = 1'b0;
          state_n = RESP;
        end
`ifdef GCD_SCHED_TIMEOUT_EN
        else if (timer == TW'(TIMEOUT_CYCLES)) begin
          eng_abort = 1'b1;
          res_n     = '0;
          err_n     = 1'b1;
          state_n   = RESP;
        end else begin
          timer_n   = timer + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          ptr_n   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign eng_a      = a_q;
  assign eng_b      = b_q;
  assign rsp_valid  = (state == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign busy       = (state != IDLE);

endmodule

// File: doc/gcd_sched.md
# gcd_sched

Scheduler that shares one GCD engine (load/compute/done datapath) among NUM_REQ requesters. Arbitrates round-robin, captures operands, starts the engine, waits for completion, and returns the result tagged with the requester ID. Zero operands bypass the engine. Sits between the bus-side request ports and the single GCD engine instance.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 32, operand/result width
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT (used only with GCD_SCHED_TIMEOUT_EN)
- ID_W, derived = max(1, $clog2(NUM_REQ)), not user-set

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  NUM_REQ*WIDTH  operand A, slice i belongs to requester i
- req_b  in  NUM_REQ*WIDTH  operand B, slice i belongs to requester i
- req_ready  out  NUM_REQ  one-hot accept
- eng_start  out  1  one-cycle engine start pulse
- eng_a, eng_b  out  WIDTH  engine operands, held stable from ISSUE until the engine completes
- eng_abort  out  1  one-cycle abort pulse (watchdog)
- eng_done  in  1  engine completion
- eng_result  in  WIDTH  engine result, valid with eng_done
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  requester index of the response
- rsp_result  out  WIDTH  GCD result
- rsp_err  out  1  response produced by timeout
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: grant = first i with req_valid[i], searching from ptr upward with wrap. If any valid:
  - req_ready[grant] = 1 combinationally in that cycle.
  - Latch a, b, and id.
  - If a==0 or b==0: result = a|b (gcd(0,0)=0), go to RESP.
  - Otherwise go to ISSUE.
- req_ready is 0 in every state other than IDLE.
- ISSUE: eng_start=1 for exactly one cycle, then go to WAIT.
- WAIT: on eng_done, latch eng_result and go to RESP. eng_done is ignored in all other states.
- RESP: rsp_valid=1. rsp_id, rsp_result and rsp_err stay stable until rsp_ready. On rsp_valid&&rsp_ready:
  - ptr = (id+1) mod NUM_REQ.
  - Go to IDLE.
- Fairness: after a requester is served, it has the lowest priority.
- Reset or reset mid-operation: state=IDLE, ptr=0, any in-flight request is discarded. eng_abort is not pulsed on reset.

## Timing
- Reset values: req_ready=0, eng_start=0, eng_a=0, eng_b=0, eng_abort=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0.
- Accept cycle T → eng_start at T+1. The earliest legal eng_done is T+2.
- eng_done at cycle D → rsp_valid from D+1.
- Zero-operand bypass: accept at T → rsp_valid at T+1.
- rsp_ready at cycle R (with rsp_valid) → earliest next accept at R+1.
- rsp_ready may be held high; back-to-back throughput is bounded only by engine latency.

## Configuration
- Macro GCD_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT, cleared on entry.
  - If TIMEOUT_CYCLES cycles elapse without eng_done:
    - eng_abort=1 for one cycle.
    - rsp_result=0, rsp_err=1, go to RESP.
  - If eng_done arrives in the same cycle as expiry, done wins and rsp_err=0.
  - A late eng_done after an abort is ignored.
- Undefined: no counter. eng_abort and rsp_err are tied to 0. WAIT waits indefinitely.

## Structure
- Package gcd_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - an id-width function;
  - the reset constants.
- Sub-module gcd_rr_arb: combinational rotating-priority picker.
  - Inputs: req_valid, ptr.
  - Outputs: any, grant index, one-hot grant.

## Test plan
- Single request: requester 2 sends a=48, b=18; engine returns 6 after 5 cycles. Expect:
  - req_ready[2] pulse;
  - eng_start one cycle after accept;
  - rsp_id=2, rsp_result=6, rsp_err=0.
- All 4 valid continuously, rsp_ready=1: grants occur in order 0,1,2,3,0. No requester is granted twice before all others are served.
- Zero bypass: a=0, b=35 → rsp_result=35 one cycle after accept, eng_start never asserted. a=0, b=0 → rsp_result=0.
- Backpressure: rsp_ready=0 for 10 cycles → rsp_valid and its fields stay stable. req_ready stays 0 while req_valid is 1.
- Reset asserted in WAIT: all outputs return to reset values immediately. The next grant after reset goes to requester 0. A stale eng_done produces no response.
- With GCD_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, engine never responds: expect a one-cycle eng_abort pulse 16 cycles after WAIT entry, then rsp_err=1, rsp_result=0.
